// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ producers,
// gated by a local free-slot credit counter so the queue is never overfilled.
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 16,
  parameter int DEPTH = 32,
  parameter int CW = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  input  logic [NREQ-1:0]    ENABLE,
  output logic [NREQ-1:0]    ACK,
  output logic               FIFO_WR,
  output logic [DW-1:0]      FIFO_DIN,
  input  logic               FIFO_RD,
  input  logic               FIFO_EMPTY,
  output logic [CW-1:0]      CREDIT,
  output logic               STALL
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, win;
  logic [NREQ-1:0] elig;
  logic found, grant, inc;
  // masking by ACK keeps a requester still holding REQ in its ACK cycle from a double grant
  assign elig = REQ & ENABLE & ~ACK;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && elig[(int'(ptr) + k) % NREQ]) begin
        win = PW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
  end
  assign grant = found && CREDIT != '0;
  assign inc = FIFO_RD && !FIFO_EMPTY;
  always_ff @(posedge CLK) begin
    if (RST) begin
      FIFO_WR <= 1'b0;
      FIFO_DIN <= '0;
      ACK <= '0;
      STALL <= 1'b0;
      ptr <= '0;
      CREDIT <= CW'(DEPTH - 1);
    end else begin
      FIFO_WR <= grant;
      ACK <= grant ? NREQ'(1) << win : '0;
      STALL <= found && CREDIT == '0;
      CREDIT <= grant && !inc ? CREDIT - CW'(1) : !grant && inc ? CREDIT + CW'(1) : CREDIT;
      if (grant) begin
        FIFO_DIN <= REQ_DATA[win*DW +: DW];
        ptr <= PW'((int'(win) + 1) % NREQ);
      end
      assert (!(grant && !inc && CREDIT == '0) && !(inc && !grant && CREDIT == CW'(DEPTH - 1)));
    end
  end
endmodule
